// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake state, memory arbiter FSM
// state, and the arbitration rule that decides which requester is granted next.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IGRANT = 3'd1,
    DGRANT = 3'd2,
    HALTED = 3'd3,
    FAULT  = 3'd4
  } arb_state_t;

  // Data normally wins; an instruction fetch wins when no data request is
  // pending or when data has already taken its maximum run of grants.
  function automatic arb_state_t arb_pick(input logic ireq,
                                          input logic dreq,
                                          input logic starved);
    if (ireq && (starved || !dreq)) return IGRANT;
    if (dreq) return DGRANT;
    return IDLE;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one RAM port between the instruction fetch and the
// data access paths. Data has priority, bounded by STARVE_MAX consecutive data
// grants while a fetch waits. Each grant may wait TIMEOUT_CYC cycles for
// ACCESS before the arbiter faults. Completion hits and load data are
// combinational in the ACCESS cycle.
// Optional build macro MEM_ARBITER_STATS_EN adds icount/dcount completion
// counters as extra output ports.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      ihit,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dhit,
  input  logic      halt,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      halted,
  output logic      err
`ifdef MEM_ARBITER_STATS_EN
  ,
  output word_t     icount,
  output word_t     dcount
`endif
);

  localparam int SCNT_W = $clog2(STARVE_MAX + 2);
  localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SCNT_W-1:0] SMAX  = SCNT_W'(STARVE_MAX);
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(TIMEOUT_CYC - 1);

  arb_state_t        state, state_nxt;
  logic [SCNT_W-1:0] starve_cnt, starve_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              dreq;

  assign dreq   = dREN | dWEN;
  assign halted = (state == HALTED);
  assign err    = (state == FAULT);

  // State and counter registers; reset drops any grant in flight at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wcnt       <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      wcnt       <= wcnt_nxt;
    end
  end

  // Next-state, RAM drive, and completion outputs for the granted requester.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    wcnt_nxt   = wcnt;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    ihit       = 1'b0;
    dhit       = 1'b0;
    iload      = '0;
    dload      = '0;
    case (state)
      IDLE: begin
        if (halt) begin
          state_nxt = HALTED;
        end else begin
          state_nxt = arb_pick(iREN, dreq, starve_cnt == SMAX);
          wcnt_nxt  = '0;
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_nxt = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          case (ramstate)
            ACCESS: begin
              ihit       = 1'b1;
              iload      = ramload;
              starve_nxt = '0;
              wcnt_nxt   = '0;
              state_nxt  = halt ? HALTED : arb_pick(iREN, dreq, 1'b0);
            end
            ERROR: state_nxt = FAULT;
            default: begin
              if (wcnt == WLAST) state_nxt = FAULT;
              else               wcnt_nxt  = wcnt + 1'b1;
            end
          endcase
        end
      end
      DGRANT: begin
        if (!dreq) begin
          state_nxt = IDLE;
        end else begin
          // A simultaneous read and write is issued as the write.
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          case (ramstate)
            ACCESS: begin
              dhit  = 1'b1;
              dload = ramload;
              if (iREN && (starve_cnt != SMAX)) starve_nxt = starve_cnt + 1'b1;
              wcnt_nxt  = '0;
              // The updated run length decides the very next grant.
              state_nxt = halt ? HALTED : arb_pick(iREN, dreq, starve_nxt == SMAX);
            end
            ERROR: state_nxt = FAULT;
            default: begin
              if (wcnt == WLAST) state_nxt = FAULT;
              else               wcnt_nxt  = wcnt + 1'b1;
            end
          endcase
        end
      end
      HALTED:  state_nxt = HALTED;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_ARBITER_STATS_EN
  // Completion counters, free-running and wrapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      if (ihit) icount <= icount + 32'd1;
      if (dhit) dcount <= dcount + 32'd1;
    end
  end
`endif

endmodule
